cv32e40p_obi_mem_responder: RTL and testbench

- Bench-side OBI responder (the memory end) for the core's data or instruction port.
- Accepts `req/addr/we/be/wdata` and grants each transaction.
- Performs the access on a word-addressed internal SRAM model and returns `rvalid/rdata` in order after a fixed, configurable latency.
- Instantiated in the testbench next to the core wrapper; one instance per port (instruction, data).

---
 rtl/cv32e40p_obi_mem_responder.sv | 101 ++++++++++
 tb/tb_cv32e40p_obi_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_mem_responder.sv
// Memory-side OBI responder: grants requests, accesses a word-addressed SRAM model
// and returns in-order responses after a fixed latency.
module cv32e40p_obi_mem_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int RESP_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_i,
  output logic                                   gnt_o,
  input  logic [31:0]                            addr_i,
  input  logic                                   we_i,
  input  logic [3:0]                             be_i,
  input  logic [31:0]                            wdata_i,
  output logic                                   rvalid_o,
  output logic [31:0]                            rdata_o,
  input  logic                                   gnt_stall_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  if (RESP_LATENCY < 1) begin : g_bad_latency
    $error("RESP_LATENCY must be at least 1");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING must be at least 1");
  end
  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("MEM_WORDS must be a power of 2 and at least 2");
  end

  logic [31:0]             mem [MEM_WORDS];
  logic [RESP_LATENCY-1:0] pipe_valid;
  logic [31:0]             pipe_data [RESP_LATENCY];
  logic [CW-1:0]           cnt;
  logic [AW-1:0]           word_idx;
  logic                    accept;
  logic                    unused_addr_bits;

  // Handshake: a request is accepted on the rising edge where req_i and gnt_o are
  // both high; responses are fire-and-forget (rvalid_o has no ready, one per cycle,
  // in acceptance order). The full check uses the registered count, so a response
  // retiring this cycle frees its slot only from the next cycle on.
  assign gnt_o    = req_i & ~gnt_stall_i & ~rst_i & (cnt < MAX_CNT);
  assign accept   = req_i & gnt_o;
  assign word_idx = addr_i[AW+1:2];
  assign unused_addr_bits = ^addr_i;

  always_ff @(posedge clk_i) begin
    if (accept && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Stage 0 captures the read word at the accept edge; writes carry zero data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pipe_data[i] <= 32'h0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= (accept && !we_i) ? mem[word_idx] : 32'h0;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[RESP_LATENCY-1];
  assign rdata_o  = pipe_data[RESP_LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (accept && !rvalid_o) begin
      cnt <= cnt + CW'(1);
    end else if (!accept && rvalid_o) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign outstanding_o = cnt;

  a_rvalid_has_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) rvalid_o |-> (cnt != '0));

  a_outstanding_bounded: assert property (
    @(posedge clk_i) disable iff (rst_i) cnt <= MAX_CNT);

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for cv32e40p_obi_mem_responder: instance 0 at latency 1, instance 1 at latency 3,
// a queue-based reference model compared every cycle, plus directed literal checks.
module tb_cv32e40p_obi_mem_responder;

  localparam int MAXO  = 2;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [2];
  logic        req         [2];
  logic        we          [2];
  logic        stall       [2];
  logic [31:0] addr        [2];
  logic [31:0] wdata       [2];
  logic [3:0]  be          [2];
  logic        gnt         [2];
  logic        rvalid      [2];
  logic [31:0] rdata       [2];
  logic [1:0]  outstanding [2];

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(1024), .RESP_LATENCY(LAT_A), .MAX_OUTSTANDING(MAXO)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .gnt_stall_i(stall[0]), .outstanding_o(outstanding[0])
  );

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(1024), .RESP_LATENCY(LAT_B), .MAX_OUTSTANDING(MAXO)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .gnt_stall_i(stall[1]), .outstanding_o(outstanding[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: memory image plus the queue of accepted-but-unanswered responses
  bit          model_ready [2];
  logic [31:0] mem_m       [2][1024];
  logic [31:0] exp_q       [2][$];
  int          due_q       [2][$];
  int          m_word;
  int          m_size;

  // Observations of the DUT, used by the directed literal checks
  int          gnt_log     [2][$];
  int          rv_cyc_log  [2][$];
  logic [31:0] rv_data_log [2][$];
  int          max_out     [2];

  function automatic int lat(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cyc=%0d actual=%h required=%h", name, i, cyc, act, exp);
    end
  endtask

  task automatic missing(input string name, input int i);
    n_checks++;
    n_errors++;
    $display("FAIL %s inst%0d cyc=%0d actual=absent required=present", name, i, cyc);
  endtask

  // sel: 0 = response data, 1 = response cycle, 2 = grant cycle
  task automatic check_log(input string name, input int i, input int sel, input int idx,
                           input logic [31:0] exp);
    if (sel == 0 && rv_data_log[i].size() > idx)     check(name, i, rv_data_log[i][idx], exp);
    else if (sel == 1 && rv_cyc_log[i].size() > idx) check(name, i, 32'(rv_cyc_log[i][idx]), exp);
    else if (sel == 2 && gnt_log[i].size() > idx)    check(name, i, 32'(gnt_log[i][idx]), exp);
    else missing(name, i);
  endtask

  // Model update at each rising edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        exp_q[i].delete();
        due_q[i].delete();
        model_ready[i] = 1'b1;
      end else if (model_ready[i]) begin
        m_size = due_q[i].size();
        if (m_size > 0 && due_q[i][0] == cyc) begin
          void'(due_q[i].pop_front());
          void'(exp_q[i].pop_front());
        end
        if (req[i] && !stall[i] && m_size < MAXO) begin
          m_word = int'((addr[i] >> 2) % 1024);
          if (we[i]) begin
            for (int b = 0; b < 4; b++)
              if (be[i][b]) mem_m[i][m_word][8*b +: 8] = wdata[i][8*b +: 8];
            exp_q[i].push_back(32'h0);
          end else begin
            exp_q[i].push_back(mem_m[i][m_word]);
          end
          due_q[i].push_back(cyc + lat(i));
        end
      end
    end
    cyc++;
  end

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (model_ready[i]) begin
        check("gnt", i, 32'(gnt[i]),
              32'(req[i] && !stall[i] && !rst[i] && due_q[i].size() < MAXO));
        if (due_q[i].size() > 0 && due_q[i][0] == cyc) begin
          check("rvalid", i, 32'(rvalid[i]), 32'd1);
          check("rdata", i, rdata[i], exp_q[i][0]);
        end else begin
          check("rvalid", i, 32'(rvalid[i]), 32'd0);
          check("rdata_idle", i, rdata[i], 32'h0);
        end
        check("outstanding", i, 32'(outstanding[i]), 32'(due_q[i].size()));
        if (gnt[i] === 1'b1) gnt_log[i].push_back(cyc);
        if (rvalid[i] === 1'b1) begin
          rv_cyc_log[i].push_back(cyc);
          rv_data_log[i].push_back(rdata[i]);
        end
        if (int'(outstanding[i]) > max_out[i]) max_out[i] = int'(outstanding[i]);
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d);
    bit done;
    done = 1'b0;
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = (gnt[i] === 1'b1);
      @(posedge clk);
      #1;
    end
    req[i] = 1'b0;
    we[i]  = 1'b0;
    if (!done) missing("txn_grant_timeout", i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  int m, g, s, n;
  bit gg;
  logic [31:0] list [4];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; stall[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; be[i] = '0; max_out[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check("reset_outstanding", 0, 32'(outstanding[0]), 32'd0);
    check("reset_rdata", 1, rdata[1], 32'h0);

    // Write/read round trip, latency 1
    m = rv_data_log[0].size();
    g = gnt_log[0].size();
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0);
    idle(3);
    check_log("rt_write_rdata", 0, 0, m, 32'h0);
    check_log("rt_read_rdata", 0, 0, m + 1, 32'hDEADBEEF);
    if (gnt_log[0].size() > g + 1)
      check_log("rt_read_latency", 0, 1, m + 1, 32'(gnt_log[0][g+1] + 1));
    else missing("rt_read_grant", 0);

    // Byte enables, including an all-zero mask
    m = rv_data_log[0].size();
    txn(0, 1'b1, 32'h10, 4'h5, 32'h11223344);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0);
    txn(0, 1'b1, 32'h14, 4'hF, 32'h01020304);
    txn(0, 1'b1, 32'h14, 4'h0, 32'hFFFFFFFF);
    txn(0, 1'b0, 32'h14, 4'h3, 32'h0);
    idle(3);
    check_log("be_merge", 0, 0, m + 1, 32'hDE22BE44);
    check_log("be_zero_response", 0, 0, m + 3, 32'h0);
    check_log("be_zero_no_update", 0, 0, m + 4, 32'h01020304);
    check("be_response_count", 0, 32'(rv_data_log[0].size() - m), 32'd5);

    // Stall for 5 cycles with a response in flight
    m = rv_data_log[0].size();
    g = gnt_log[0].size();
    s = cyc;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; stall[0] = 1'b0;
    @(posedge clk); #1;
    addr[0] = 32'h14; stall[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    stall[0] = 1'b0;
    @(posedge clk); #1;
    req[0] = 1'b0;
    idle(3);
    check_log("stall_first_gnt", 0, 2, g, 32'(s));
    check_log("stall_second_gnt", 0, 2, g + 1, 32'(s + 6));
    check_log("stall_inflight_cycle", 0, 1, m, 32'(s + 1));
    check_log("stall_inflight_data", 0, 0, m, 32'hDE22BE44);
    check_log("stall_after_cycle", 0, 1, m + 1, 32'(s + 7));
    check_log("stall_after_data", 0, 0, m + 1, 32'h01020304);

    // Address wrap modulo 4 KiB, low bits ignored
    m = rv_data_log[0].size();
    txn(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
    txn(0, 1'b0, 32'h0, 4'hF, 32'h0);
    txn(0, 1'b0, 32'h2, 4'hF, 32'h0);
    idle(3);
    check_log("wrap_read_0", 0, 0, m + 1, 32'hCAFEF00D);
    check_log("wrap_read_2", 0, 0, m + 2, 32'hCAFEF00D);

    // Outstanding limit at latency 3, limit 2
    list[0] = 32'hA0A0A0A0; list[1] = 32'hB1B1B1B1;
    list[2] = 32'hC2C2C2C2; list[3] = 32'hD3D3D3D3;
    for (int k = 0; k < 4; k++) txn(1, 1'b1, 32'h20 + 32'(4 * k), 4'hF, list[k]);
    idle(6);
    m = rv_data_log[1].size();
    g = gnt_log[1].size();
    s = cyc;
    n = 0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge clk);
      gg = (gnt[1] === 1'b1);
      @(posedge clk); #1;
      if (gg) begin
        n++;
        if (n < 4) addr[1] = 32'h20 + 32'(4 * n);
      end
    end
    req[1] = 1'b0;
    if (n < 4) missing("burst_grant_timeout", 1);
    idle(6);
    check_log("burst_gnt0", 1, 2, g, 32'(s));
    check_log("burst_gnt1", 1, 2, g + 1, 32'(s + 1));
    check_log("burst_gnt2", 1, 2, g + 2, 32'(s + 4));
    check_log("burst_gnt3", 1, 2, g + 3, 32'(s + 5));
    check_log("burst_rv0", 1, 1, m, 32'(s + 3));
    check_log("burst_rv1", 1, 1, m + 1, 32'(s + 4));
    check_log("burst_rv2", 1, 1, m + 2, 32'(s + 7));
    check_log("burst_rv3", 1, 1, m + 3, 32'(s + 8));
    for (int k = 0; k < 4; k++) check_log("burst_data", 1, 0, m + k, list[k]);
    check("burst_max_outstanding_le_2", 1, 32'(max_out[1] <= 2), 32'd1);

    // Reset with two reads in flight
    m = rv_data_log[1].size();
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0);
    txn(1, 1'b0, 32'h24, 4'hF, 32'h0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    check("reset_mid_outstanding", 1, 32'(outstanding[1]), 32'd0);
    idle(5);
    check("reset_no_rvalid", 1, 32'(rv_data_log[1].size() - m), 32'd0);
    m = rv_data_log[1].size();
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0);
    txn(1, 1'b0, 32'h24, 4'hF, 32'h0);
    idle(5);
    check_log("reset_mem_kept_0", 1, 0, m, 32'hA0A0A0A0);
    check_log("reset_mem_kept_1", 1, 0, m + 1, 32'hB1B1B1B1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
